// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial deserializer slice.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shift register: new serial bit enters at the MSB, so an LSB-first
// stream lands in natural bit order after WIDTH shifts. Falling-edge clocked.
module serial_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next-state selection: clear, shift in, or hold.
    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = {d, sr_q[WIDTH-1:1]};
        end else begin
            sr_d = sr_q;
        end
    end

    // State register.
    always_ff @(negedge clock) begin
        sr_q <= sr_d;
    end

    assign q = sr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Start/data/stop framing receiver with a one-word valid/ready holding register.
// Optional even parity check enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             d,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             frame_error,
    output logic             parity_error,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             shift_en_s;
    logic             complete_s;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic             par_q, par_d;
    logic             pmis_q, pmis_d;
    logic             perr_q, perr_d;
`endif

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clock    (clock),
        .clear    (clear),
        .shift_en (shift_en_s),
        .d        (d),
        .q        (word_s)
    );

    // Framing FSM, bit counter and parity accumulator.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_en_s = 1'b0;
        complete_s = 1'b0;
        ferr_d     = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        par_d      = par_q;
        pmis_d     = pmis_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (d == START_LEVEL) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    par_d   = 1'b0;
                    pmis_d  = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                shift_en_s = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                par_d      = par_q ^ d;
`endif
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                pmis_d  = par_q ^ d;
`endif
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                // A bad stop bit outranks a parity mismatch in the same frame.
                if (d != STOP_LEVEL) begin
                    ferr_d = 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                end else if (pmis_q) begin
                    perr_d = 1'b1;
`endif
                end else begin
                    complete_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register: load on completion if free or freed this edge, else drop.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (complete_s) begin
            if (!valid_q || ready) begin
                hold_d  = word_s;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous clear.
    always_ff @(negedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            par_q   <= 1'b0;
            pmis_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            par_q   <= par_d;
            pmis_q  <= pmis_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign q           = hold_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel receiver that consumes the single-bit stream produced by the team's D flip-flop stages. It frames start/data/stop bits into a WIDTH-bit word. The word is presented on a valid/ready handshake with one holding register. Framing, parity and overrun faults are flagged to the downstream consumer.

## Interface
- WIDTH, 8, number of data bits per frame (≥2)
- clock  input  1  system clock; all state updates on the falling edge
- clear  input  1  reset, synchronous, active-high; sampled on the falling edge of clock
- d  input  1  serial line; idle level 1, one bit per clock
- ready  input  1  consumer accepts q this edge when valid is also high
- q  output  WIDTH  received word, LSB received first
- valid  output  1  q holds an unconsumed word
- frame_error  output  1  one-cycle pulse: stop bit sampled as 0
- parity_error  output  1  one-cycle pulse: parity mismatch (constant 0 without PARITY_EN)
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full

## Operation
- Frame format: start bit (0), WIDTH data bits LSB first, optional even-parity bit, stop bit (1).
- States:
  - IDLE: d=0 → DATA with bit_cnt=0; d=1 → stay.
  - DATA: shift d into shift register MSB, which shifts right; bit_cnt+1. After the WIDTH-th bit → PARITY if enabled, else STOP.
  - PARITY: compare d against XOR of the shifted word (even parity: XOR(data)^d must be 0) → STOP; record mismatch.
  - STOP: d=1 and no parity mismatch → word complete. d=0 → frame_error, word discarded. Parity mismatch with d=1 → parity_error, word discarded. Always → IDLE.
- Completion with holding register empty, or emptied this same edge by valid&&ready: q ← word, valid=1.
- Completion with valid=1 and ready=0: overrun pulse, new word dropped, q/valid unchanged.
- Handshake: valid&&ready at an edge consumes q; valid falls that edge unless a new word loads on it. q is stable while valid=1.
- If frame_error and parity_error are both detected in one frame, only frame_error pulses.
- bit_cnt width: $clog2(WIDTH+1); no wrap possible, resets to 0 on entering DATA.

## Timing
- Reset: state=IDLE, bit_cnt=0, shift register=0, q=0, valid=0, frame_error=0, parity_error=0, overrun=0.
- Reset mid-frame aborts the frame with no pulses. Start detection resumes on the first edge after clear deasserts.
- clear takes priority over a simultaneous handshake or completion.
- Start bit sampled at edge k. Without parity, valid rises at edge k+WIDTH+1; with parity, at edge k+WIDTH+2.
- Error pulses are asserted for exactly one edge-to-edge period, on the edge that samples the stop bit.
- Back-to-back frames: a start bit on the edge immediately after the stop edge is accepted. Sustained throughput is one word per WIDTH+2 (+1) clocks.
- ready has no combinational path to any output.

## Configuration
- SERIAL_DESERIALIZER_PARITY_EN defined: the PARITY state exists, even parity is checked, and parity_error is live. The frame is WIDTH+3 bits.
- Undefined: no PARITY state; DATA goes directly to STOP. parity_error is tied 0 and the port is kept. The frame is WIDTH+2 bits.

## Structure
- Package serial_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP)
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
- Sub-module serial_shift_reg: WIDTH-bit right-shift register with shift enable and synchronous clear, falling-edge clocked. The top level holds the FSM, counter, parity accumulator and holding register.

## Test plan
- Defaults used unless stated: WIDTH=8, no parity, ready=1.
- Send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) with start at edge 1 → valid high after edge 10, q=0xA5, no error pulses.
- Stop bit forced to 0 on 0x3C → frame_error pulses at the stop edge, valid stays 0. A following correct 0x3C frame starting the next edge → q=0x3C.
- ready=0, send 0x11 then 0x22 back-to-back → q=0x11 held, overrun pulses at the second stop edge. Raise ready → valid falls, q stays 0x11.
- ready=1 asserted on the same edge that 0x22 completes while 0x11 is pending → q=0x22, valid stays 1, no overrun.
- Assert clear at edge 5 mid-frame for one cycle → all outputs 0. The next full frame 0xFF → q=0xFF.
- With SERIAL_DESERIALIZER_PARITY_EN:
  - 0xA5 with parity bit 0 → valid at edge 11.
  - 0xA5 with parity bit 1 → parity_error pulses at edge 11, valid stays 0.
